// File: rtl/mac_v2_pipe.sv
// mac_v2_pipe: three-stage pipelined multiply-accumulate for dot products.
// S1 registers operands, S2 registers the extended product, and S3 accumulates
// the product into a frame. Each completed frame is dumped to result with a
// one-cycle out_valid pulse. A frame length of zero selects running mode.
module mac_v2_pipe #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 22,
  parameter int unsigned LW       = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  output logic [AW-1:0] result,
  output logic          overflow
);

  if (AW < 2 * DW) begin : g_aw_check
    $error("mac_v2_pipe: AW must be at least 2*DW");
  end

  // Stage 1 state
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          v1_q, v1_d;

  // Stage 2 state
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [AW-1:0]          p_q, p_d;
  logic                   v2_q, v2_d;

  // Stage 3 state
  logic [AW-1:0] acc_q, acc_d, result_q, result_d;
  logic [LW-1:0] cnt_q, cnt_d, len_l_q, len_l_d;
  logic          ovf_q, ovf_d, overflow_q, overflow_d, out_valid_q, out_valid_d;

  // Stage 3 datapath helpers
  logic [AW-1:0] base, sum_sat;
  logic [AW:0]   sum_w;
  logic [LW-1:0] len_eff;
  logic          this_ovf, running, last;

  // Stage 1: capture operands of an accepted term; clr drops the incoming term
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    v1_d = in_valid & ~clr;
    if (in_valid) begin
      a_d = a;
      b_d = b;
    end
  end

  // Stage 2: full-width product, sign- or zero-extended to the accumulator width
  always_comb begin
    prod_u = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    prod_s = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});
    if (SIGNED) begin
      p_d = AW'(prod_s);
    end else begin
      p_d = AW'(prod_u);
    end
    v2_d = v1_q & ~clr;
  end

  // Stage 3: accumulate, detect overflow, clamp or wrap, dump on frame end
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_l_d     = len_l_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;

    // len is only sampled at frame start; mid-frame changes are ignored
    len_eff = (cnt_q == '0) ? len : len_l_q;
    running = (len_eff == '0);
    last    = (cnt_q == len_eff - LW'(1));
    // A new frame ignores the accumulator; running mode keeps summing
    base    = (cnt_q == '0 && !running) ? '0 : acc_q;

    if (SIGNED) begin
      sum_w    = {base[AW-1], base} + {p_q[AW-1], p_q};
      this_ovf = (base[AW-1] == p_q[AW-1]) && (sum_w[AW-1] != p_q[AW-1]);
    end else begin
      sum_w    = {1'b0, base} + {1'b0, p_q};
      this_ovf = sum_w[AW];
    end

    sum_sat = sum_w[AW-1:0];
    if (this_ovf && SATURATE) begin
      if (SIGNED) begin
        // Overflow direction follows the sign of the product
        sum_sat = p_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
        sum_sat = '1;
      end
    end

    if (clr) begin
      acc_d      = '0;
      cnt_d      = '0;
      len_l_d    = '0;
      ovf_d      = 1'b0;
      result_d   = '0;
      overflow_d = 1'b0;
    end else if (v2_q) begin
      len_l_d = len_eff;
      if (running) begin
        acc_d       = sum_sat;
        result_d    = sum_sat;
        ovf_d       = ovf_q | this_ovf;
        overflow_d  = ovf_q | this_ovf;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else if (last) begin
        result_d    = sum_sat;
        overflow_d  = ovf_q | this_ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_q + LW'(1);
        ovf_d = ovf_q | this_ovf;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      p_q         <= '0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_l_q     <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      p_q         <= p_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_l_q     <= len_l_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule
